dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: latches one CPU transfer, waits WAIT cycles,
// then answers with a registered one-cycle ack carrying load data or a fault flag.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                we_r;
  logic [31:0]         addr_r;
  logic [31:0]         wdata_r;
  logic [3:0]          be_r;
  logic [31:0]         mem_r [0:DEPTH-1];
  logic                fault_s;
  logic                resp_s;
  logic [ADDR_W-1:0]   idx_s;

  // Misaligned or beyond the implemented word range.
  function automatic logic addr_fault(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (ADDR_W + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = en[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return m;
  endfunction

  assign fault_s = addr_fault(addr_r);
  assign resp_s  = (state_r == ST_RESP);
  assign idx_s   = addr_r[ADDR_W+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          cnt_s   = 4'(WAIT);
          state_s = (WAIT > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State register and request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == ST_IDLE && req) begin
        we_r    <= we;
        addr_r  <= addr;
        wdata_r <= wdata;
        be_r    <= be;
      end
    end
  end

  // Registered response: the RESP cycle's result appears on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ack   <= resp_s;
      err   <= resp_s && fault_s;
      rdata <= (resp_s && !we_r && !fault_s) ? mem_r[idx_s] : 32'd0;
    end
  end

  // Memory contents survive reset; a reset on the RESP edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && resp_s && we_r && !fault_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata_r, be_r);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: vector table on a WAIT=2 instance, back-to-back traffic on a
// WAIT=0 instance, plus hand sequences for reset and committed-transaction cases.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        ack, err;
  logic [31:0] rdata;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [3:0]  be0 = 4'd0;
  logic        ack0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vt [22];
  vec_t v0 [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One WAIT=2 transfer; lat is the edge count from sampling to visible ack.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int lat, output logic [31:0] rd,
                      output logic e, output logic ack_after);
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b; req = 1'b1;
    @(posedge clk);
    lat = 0; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    ack_after = ack;
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic e, aa;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF,  1'b0};
    vt[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0,          1'b0};
    vt[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0100, 32'h0,          1'b0};
    vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_3344,  1'b0};
    vt[5]  = '{1'b1, 32'h0000_0020, 32'h5566_7788, 4'b1001, 32'h0,          1'b0};
    vt[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h55BB_3388,  1'b0};
    vt[7]  = '{1'b0, 32'h0000_0002, 32'h0,         4'b1111, 32'h0,          1'b1};
    vt[8]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0,          1'b0};
    vt[9]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'b1111, 32'h0,          1'b1};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'hCAFE_F00D,  1'b0};
    vt[11] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0};
    vt[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF,  1'b0};
    vt[13] = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'b1111, 32'h0,          1'b0};
    vt[14] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0001, 32'h0BAD_F00D,  1'b0};
    vt[15] = '{1'b1, 32'h0000_0013, 32'h7777_7777, 4'b1111, 32'h0,          1'b1};
    vt[16] = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF,  1'b0};
    vt[17] = '{1'b0, 32'h8000_0010, 32'h0,         4'b1111, 32'h0,          1'b1};
    vt[18] = '{1'b1, 32'h0000_0030, 32'h0102_0304, 4'b1111, 32'h0,          1'b0};
    vt[19] = '{1'b1, 32'h0000_0040, 32'h4040_4040, 4'b1111, 32'h0,          1'b0};
    vt[20] = '{1'b1, 32'h0000_0044, 32'h4444_4444, 4'b1111, 32'h0,          1'b0};
    vt[21] = '{1'b0, 32'h0000_0044, 32'h0,         4'b1111, 32'h4444_4444,  1'b0};

    v0[0] = '{1'b1, 32'h0000_0100, 32'hA000_0001, 4'b1111, 32'h0,         1'b0};
    v0[1] = '{1'b1, 32'h0000_0104, 32'hA000_0002, 4'b1111, 32'h0,         1'b0};
    v0[2] = '{1'b1, 32'h0000_0108, 32'hA000_0003, 4'b1111, 32'h0,         1'b0};
    v0[3] = '{1'b1, 32'h0000_010C, 32'hA000_0004, 4'b1111, 32'h0,         1'b0};
    v0[4] = '{1'b0, 32'h0000_010C, 32'h0,         4'b1111, 32'hA000_0004, 1'b0};
    v0[5] = '{1'b0, 32'h0000_0108, 32'h0,         4'b1111, 32'hA000_0003, 1'b0};
    v0[6] = '{1'b0, 32'h0000_0106, 32'h0,         4'b1111, 32'h0,         1'b1};
    v0[7] = '{1'b0, 32'h0000_0100, 32'h0,         4'b1111, 32'hA000_0001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack0", ack0, 32'd0);
    rst = 1'b0;

    // WAIT=0 with req held high: one ack every second cycle.
    @(negedge clk);
    we0 = v0[0].w; addr0 = v0[0].a; wdata0 = v0[0].d; be0 = v0[0].b; req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k > 0) chk("b2b_gap", ack0, 32'd0);
      if (k < 7) begin
        we0 = v0[k+1].w; addr0 = v0[k+1].a; wdata0 = v0[k+1].d; be0 = v0[k+1].b;
      end else begin
        req0 = 1'b0;
      end
      @(posedge clk); #1;
      chk("b2b_ack", ack0, 32'd1);
      chk("b2b_rdata", rdata0, v0[k].er);
      chk("b2b_err", err0, 32'(v0[k].ee));
    end

    for (int i = 0; i < 22; i++) begin
      xact(vt[i].w, vt[i].a, vt[i].d, vt[i].b, lat, rd, e, aa);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].er);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].ee));
      chk($sformatf("v%0d_pulse", i), 32'(aa), 32'd0);
    end

    // Reset while in WAIT: store is dropped, no ack.
    @(negedge clk);
    we = 1'b1; addr = 32'h30; wdata = 32'h9999_9999; be = 4'hF; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_wait_ack", ack, 32'd0);
    end

    // Reset on the edge leaving RESP: no ack, no write.
    @(negedge clk);
    we = 1'b1; addr = 32'h30; wdata = 32'h8888_8888; be = 4'hF; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_resp_ack", ack, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_resp_ack_late", ack, 32'd0);
    end

    // Reset beats a simultaneous request.
    @(negedge clk);
    we = 1'b1; addr = 32'h30; wdata = 32'h7777_7777; be = 4'hF; req = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_prio_ack", ack, 32'd0);
    end

    xact(1'b0, 32'h30, 32'h0, 4'hF, lat, rd, e, aa);
    chk("rst_mem_lat", 32'(lat), 32'd3);
    chk("rst_mem_rdata", rd, 32'h0102_0304);

    // Inputs changed right after sampling must not affect the committed load.
    @(negedge clk);
    we = 1'b0; addr = 32'h40; wdata = 32'h0; be = 4'hF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b1; addr = 32'h44; wdata = 32'h5A5A_5A5A;
    lat = 0; rd = 32'd0; e = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    chk("commit_lat", 32'(lat), 32'd3);
    chk("commit_rdata", rd, 32'h4040_4040);
    chk("commit_err", 32'(e), 32'd0);
    xact(1'b0, 32'h44, 32'h0, 4'hF, lat, rd, e, aa);
    chk("commit_nowrite", rd, 32'h4444_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
